// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the IFU, the LSU and the core memory port.
// slave  : the arbiter's view (requests in, grants/responses out, memory port out)
// master : the environment's view (requesters and memory)
interface mem_bus_arbiter_if;
   logic        ifu_valid;
   logic        ifu_ready;
   logic [31:0] ifu_addr;
   logic        ifu_rvalid;
   logic [31:0] ifu_rdata;
   logic        ifu_err;

   logic        lsu_valid;
   logic        lsu_ready;
   logic [31:0] lsu_addr;
   logic        lsu_wen;
   logic [31:0] lsu_wdata;
   logic [3:0]  lsu_wmask;
   logic        lsu_rvalid;
   logic [31:0] lsu_rdata;
   logic        lsu_err;

   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   logic [1:0]  owner_out;

   modport slave (
      input  ifu_valid, ifu_addr,
      input  lsu_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
      input  mem_ready, mem_rvalid, mem_rdata,
      output ifu_ready, ifu_rvalid, ifu_rdata, ifu_err,
      output lsu_ready, lsu_rvalid, lsu_rdata, lsu_err,
      output mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      output owner_out
   );

   modport master (
      output ifu_valid, ifu_addr,
      output lsu_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
      output mem_ready, mem_rvalid, mem_rdata,
      input  ifu_ready, ifu_rvalid, ifu_rdata, ifu_err,
      input  lsu_ready, lsu_rvalid, lsu_rdata, lsu_err,
      input  mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      input  owner_out
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares the core memory port between IFU (read-only) and LSU (read/write).
// One request is granted and latched at a time, driven to memory until the
// response returns, then routed back to its owner only. A watchdog forces an
// error response if memory never answers.
// Ports: clk, rst (sync, active-high), bus (mem_bus_arbiter_if.slave).
//
// state  | meaning
// S_IDLE | no owner; arbitrate and accept one request
// S_REQ  | mem_valid high with latched fields, waiting for mem_ready
// S_RESP | request taken by memory, waiting for mem_rvalid
module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT = 1024,
   parameter bit          RR_MODE = 1'b0
) (
   input logic              clk,
   input logic              rst,
   mem_bus_arbiter_if.slave bus
);
   localparam int unsigned   CW       = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [1:0]    OWN_NONE = 2'b00;
   localparam logic [1:0]    OWN_IFU  = 2'b01;
   localparam logic [1:0]    OWN_LSU  = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

   state_e        state_q, state_d;
   logic [1:0]    owner_q, owner_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          wen_q, wen_d;
   logic [3:0]    wmask_q, wmask_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          favour_lsu_q, favour_lsu_d;

   logic          sel_ifu, sel_lsu, cnt_last;
   logic          mem_valid_c, resp_v, resp_err;
   logic [31:0]   resp_data;
   logic          to_ifu, to_lsu;

   // On a tie the LSU wins in fixed-priority mode; in round-robin mode the
   // pointer says which side did not own the bus last.
   assign sel_lsu  = bus.lsu_valid && (!bus.ifu_valid || !RR_MODE || favour_lsu_q);
   assign sel_ifu  = bus.ifu_valid && !sel_lsu;
   assign cnt_last = (cnt_q == CNT_LAST);

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wen_d        = wen_q;
      wmask_d      = wmask_q;
      cnt_d        = cnt_q;
      favour_lsu_d = favour_lsu_q;
      mem_valid_c  = 1'b0;
      resp_v       = 1'b0;
      resp_err     = 1'b0;
      resp_data    = '0;
      case (state_q)
         S_IDLE: begin
            if (sel_lsu) begin
               owner_d      = OWN_LSU;
               addr_d       = bus.lsu_addr;
               wen_d        = bus.lsu_wen;
               wdata_d      = bus.lsu_wdata;
               wmask_d      = bus.lsu_wmask;
               cnt_d        = '0;
               favour_lsu_d = 1'b0;
               state_d      = S_REQ;
            end else if (sel_ifu) begin
               owner_d      = OWN_IFU;
               addr_d       = bus.ifu_addr;
               wen_d        = 1'b0;
               wdata_d      = '0;
               wmask_d      = 4'b0000;
               cnt_d        = '0;
               favour_lsu_d = 1'b1;
               state_d      = S_REQ;
            end
         end
         S_REQ: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_last) begin
               // Memory never took the request: drop it and report an error.
               resp_v   = 1'b1;
               resp_err = 1'b1;
               owner_d  = OWN_NONE;
               state_d  = S_IDLE;
            end else begin
               mem_valid_c = 1'b1;
               if (bus.mem_ready) state_d = S_RESP;
            end
         end
         S_RESP: begin
            cnt_d = cnt_q + CW'(1);
            if (bus.mem_rvalid) begin
               // A real response on the last watchdog cycle still wins.
               resp_v    = 1'b1;
               resp_data = bus.mem_rdata;
               owner_d   = OWN_NONE;
               state_d   = S_IDLE;
            end else if (cnt_last) begin
               resp_v   = 1'b1;
               resp_err = 1'b1;
               owner_d  = OWN_NONE;
               state_d  = S_IDLE;
            end
         end
         default: begin
            owner_d = OWN_NONE;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         owner_q      <= OWN_NONE;
         addr_q       <= '0;
         wdata_q      <= '0;
         wen_q        <= 1'b0;
         wmask_q      <= 4'b0000;
         cnt_q        <= '0;
         favour_lsu_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wen_q        <= wen_d;
         wmask_q      <= wmask_d;
         cnt_q        <= cnt_d;
         favour_lsu_q <= favour_lsu_d;
      end
   end

   // Outputs are forced low while rst is held so an abandoned transaction
   // cannot leak a response during the reset cycle.
   assign to_ifu = !rst && resp_v && (owner_q == OWN_IFU);
   assign to_lsu = !rst && resp_v && (owner_q == OWN_LSU);

   assign bus.ifu_ready  = !rst && (state_q == S_IDLE) && sel_ifu;
   assign bus.lsu_ready  = !rst && (state_q == S_IDLE) && sel_lsu;
   assign bus.ifu_rvalid = to_ifu;
   assign bus.ifu_rdata  = to_ifu ? resp_data : '0;
   assign bus.ifu_err    = to_ifu && resp_err;
   assign bus.lsu_rvalid = to_lsu;
   assign bus.lsu_rdata  = to_lsu ? resp_data : '0;
   assign bus.lsu_err    = to_lsu && resp_err;
   assign bus.mem_valid  = !rst && mem_valid_c;
   assign bus.mem_addr   = rst ? '0 : addr_q;
   assign bus.mem_wen    = !rst && wen_q;
   assign bus.mem_wdata  = rst ? '0 : wdata_q;
   assign bus.mem_wmask  = rst ? 4'b0000 : wmask_q;
   assign bus.owner_out  = rst ? OWN_NONE : owner_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Two arbiters side by side: lane 0 fixed priority, lane 1 round-robin, both
// with a short watchdog. A transaction-level model predicts every output of
// both lanes each cycle; directed sequences add literal expectations.
module tb_mem_bus_arbiter;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0]       i_ifu_valid, i_lsu_valid, i_lsu_wen, i_mem_ready, i_mem_rvalid;
   logic [1:0][31:0] i_ifu_addr, i_lsu_addr, i_lsu_wdata, i_mem_rdata;
   logic [1:0][3:0]  i_lsu_wmask;

   logic [1:0]       o_ifu_ready, o_ifu_rvalid, o_ifu_err, o_lsu_ready, o_lsu_rvalid, o_lsu_err;
   logic [1:0]       o_mem_valid, o_mem_wen;
   logic [1:0][31:0] o_ifu_rdata, o_lsu_rdata, o_mem_addr, o_mem_wdata;
   logic [1:0][3:0]  o_mem_wmask;
   logic [1:0][1:0]  o_owner;

   mem_bus_arbiter_if bus0();
   mem_bus_arbiter_if bus1();

   mem_bus_arbiter #(.TIMEOUT(TO), .RR_MODE(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
   mem_bus_arbiter #(.TIMEOUT(TO), .RR_MODE(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

   assign bus0.ifu_valid  = i_ifu_valid[0];
   assign bus0.ifu_addr   = i_ifu_addr[0];
   assign bus0.lsu_valid  = i_lsu_valid[0];
   assign bus0.lsu_addr   = i_lsu_addr[0];
   assign bus0.lsu_wen    = i_lsu_wen[0];
   assign bus0.lsu_wdata  = i_lsu_wdata[0];
   assign bus0.lsu_wmask  = i_lsu_wmask[0];
   assign bus0.mem_ready  = i_mem_ready[0];
   assign bus0.mem_rvalid = i_mem_rvalid[0];
   assign bus0.mem_rdata  = i_mem_rdata[0];
   assign bus1.ifu_valid  = i_ifu_valid[1];
   assign bus1.ifu_addr   = i_ifu_addr[1];
   assign bus1.lsu_valid  = i_lsu_valid[1];
   assign bus1.lsu_addr   = i_lsu_addr[1];
   assign bus1.lsu_wen    = i_lsu_wen[1];
   assign bus1.lsu_wdata  = i_lsu_wdata[1];
   assign bus1.lsu_wmask  = i_lsu_wmask[1];
   assign bus1.mem_ready  = i_mem_ready[1];
   assign bus1.mem_rvalid = i_mem_rvalid[1];
   assign bus1.mem_rdata  = i_mem_rdata[1];

   assign o_ifu_ready  = {bus1.ifu_ready,  bus0.ifu_ready};
   assign o_ifu_rvalid = {bus1.ifu_rvalid, bus0.ifu_rvalid};
   assign o_ifu_err    = {bus1.ifu_err,    bus0.ifu_err};
   assign o_ifu_rdata  = {bus1.ifu_rdata,  bus0.ifu_rdata};
   assign o_lsu_ready  = {bus1.lsu_ready,  bus0.lsu_ready};
   assign o_lsu_rvalid = {bus1.lsu_rvalid, bus0.lsu_rvalid};
   assign o_lsu_err    = {bus1.lsu_err,    bus0.lsu_err};
   assign o_lsu_rdata  = {bus1.lsu_rdata,  bus0.lsu_rdata};
   assign o_mem_valid  = {bus1.mem_valid,  bus0.mem_valid};
   assign o_mem_wen    = {bus1.mem_wen,    bus0.mem_wen};
   assign o_mem_addr   = {bus1.mem_addr,   bus0.mem_addr};
   assign o_mem_wdata  = {bus1.mem_wdata,  bus0.mem_wdata};
   assign o_mem_wmask  = {bus1.mem_wmask,  bus0.mem_wmask};
   assign o_owner      = {bus1.owner_out,  bus0.owner_out};

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input int l, input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL L%0d %s: got %0h expected %0h at %0t", l, nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: one outstanding transaction per lane, tracked
   // by its age in cycles since acceptance and whether memory has taken it.
   bit         m_busy[2];
   bit         m_hs[2];
   int         m_age[2];
   logic [1:0] m_own[2];
   bit         m_last_ifu[2];
   logic [31:0] m_addr[2], m_wdata[2];
   logic       m_wen[2];
   logic [3:0] m_wmask[2];

   always @(negedge clk) begin
      for (int l = 0; l < 2; l++) begin
         logic e_ir, e_lr, e_mv, e_irv, e_lrv, e_err, e_wen, fin, done_real, chk_bus;
         logic [31:0] e_rdata, e_addr, e_wdata;
         logic [3:0]  e_wmask;
         logic [1:0]  e_own;
         e_ir = 0; e_lr = 0; e_mv = 0; e_irv = 0; e_lrv = 0; e_err = 0; e_wen = 0;
         fin = 0; done_real = 0; chk_bus = 0;
         e_rdata = 0; e_addr = 0; e_wdata = 0; e_wmask = 0; e_own = 0;
         if (rst) begin
            chk_bus       = 1;
            m_busy[l]     = 0;
            m_last_ifu[l] = 1;
         end else if (!m_busy[l]) begin
            int pick;
            pick = 0;
            if (i_lsu_valid[l] && (!i_ifu_valid[l] || l == 0 || m_last_ifu[l])) pick = 2;
            else if (i_ifu_valid[l]) pick = 1;
            e_ir = (pick == 1);
            e_lr = (pick == 2);
            if (pick != 0) begin
               m_busy[l]     = 1;
               m_hs[l]       = 0;
               m_age[l]      = 1;
               m_own[l]      = 2'(pick);
               m_last_ifu[l] = (pick == 1);
               m_addr[l]     = (pick == 2) ? i_lsu_addr[l]  : i_ifu_addr[l];
               m_wen[l]      = (pick == 2) ? i_lsu_wen[l]   : 1'b0;
               m_wdata[l]    = (pick == 2) ? i_lsu_wdata[l] : 32'h0;
               m_wmask[l]    = (pick == 2) ? i_lsu_wmask[l] : 4'h0;
            end
         end else begin
            chk_bus   = 1;
            e_own     = m_own[l];
            e_addr    = m_addr[l];
            e_wen     = m_wen[l];
            e_wmask   = m_wmask[l];
            if (m_own[l] == 2'd2) e_wdata = m_wdata[l];
            else e_wdata = 32'h0;
            done_real = m_hs[l] && i_mem_rvalid[l];
            fin       = done_real || (m_age[l] == TO);
            e_mv      = !m_hs[l] && !fin;
            if (fin) begin
               e_irv     = (m_own[l] == 2'd1);
               e_lrv     = (m_own[l] == 2'd2);
               e_err     = !done_real;
               e_rdata   = done_real ? i_mem_rdata[l] : 32'h0;
               m_busy[l] = 0;
            end else begin
               if (!m_hs[l] && i_mem_ready[l]) m_hs[l] = 1;
               m_age[l]++;
            end
         end
         chk(l, "ifu_ready",  64'(o_ifu_ready[l]),  64'(e_ir));
         chk(l, "lsu_ready",  64'(o_lsu_ready[l]),  64'(e_lr));
         chk(l, "mem_valid",  64'(o_mem_valid[l]),  64'(e_mv));
         chk(l, "ifu_rvalid", 64'(o_ifu_rvalid[l]), 64'(e_irv));
         chk(l, "lsu_rvalid", 64'(o_lsu_rvalid[l]), 64'(e_lrv));
         chk(l, "owner_out",  64'(o_owner[l]),      64'(e_own));
         if (e_irv || rst) begin
            chk(l, "ifu_rdata", 64'(o_ifu_rdata[l]), 64'(e_rdata));
            chk(l, "ifu_err",   64'(o_ifu_err[l]),   64'(e_err));
         end
         if (e_lrv || rst) begin
            chk(l, "lsu_rdata", 64'(o_lsu_rdata[l]), 64'(e_rdata));
            chk(l, "lsu_err",   64'(o_lsu_err[l]),   64'(e_err));
         end
         if (chk_bus) begin
            chk(l, "mem_addr",     64'(o_mem_addr[l]),  64'(e_addr));
            chk(l, "mem_wdata",    64'(o_mem_wdata[l]), 64'(e_wdata));
            chk(l, "mem_wen_mask", 64'({o_mem_wen[l], o_mem_wmask[l]}), 64'({e_wen, e_wmask}));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ifu(input logic v, input logic [31:0] a);
      for (int l = 0; l < 2; l++) begin
         i_ifu_valid[l] = v;
         i_ifu_addr[l]  = a;
      end
   endtask

   task automatic set_lsu(input logic v, input logic [31:0] a, input logic w,
                          input logic [31:0] d, input logic [3:0] m);
      for (int l = 0; l < 2; l++) begin
         i_lsu_valid[l] = v;
         i_lsu_addr[l]  = a;
         i_lsu_wen[l]   = w;
         i_lsu_wdata[l] = d;
         i_lsu_wmask[l] = m;
      end
   endtask

   task automatic set_mem(input logic rdy, input logic rv, input logic [31:0] d);
      for (int l = 0; l < 2; l++) begin
         i_mem_ready[l]  = rdy;
         i_mem_rvalid[l] = rv;
         i_mem_rdata[l]  = d;
      end
   endtask

   initial begin
      int gcnt[2], gseq[2], found_at[2], ifu_rdy0;
      logic [1:0] f_err[2];
      logic [31:0] f_data[2];

      rst = 1'b1;
      set_ifu(0, 0);
      set_lsu(0, 0, 0, 0, 0);
      set_mem(0, 0, 0);

      // Reset state
      step();
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
         chk(l, "rst_owner", 64'(o_owner[l]), 64'(0));
         chk(l, "rst_mem_valid", 64'(o_mem_valid[l]), 64'(0));
      end
      step();
      rst = 1'b0;

      // Single IFU read
      set_ifu(1, 32'h8000_0000);
      @(negedge clk);
      for (int l = 0; l < 2; l++) chk(l, "ifu_accept", 64'(o_ifu_ready[l]), 64'(1));
      step();
      set_ifu(0, 32'h1111_1111);
      set_mem(1, 0, 0);
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
         chk(l, "ifu_mem_valid", 64'(o_mem_valid[l]), 64'(1));
         chk(l, "ifu_mem_addr",  64'(o_mem_addr[l]),  64'(32'h8000_0000));
         chk(l, "ifu_mem_wmask", 64'(o_mem_wmask[l]), 64'(0));
         chk(l, "ifu_owner",     64'(o_owner[l]),     64'(1));
      end
      step();
      set_mem(0, 1, 32'h0000_0413);
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
         chk(l, "ifu_rvalid_pulse", 64'(o_ifu_rvalid[l]), 64'(1));
         chk(l, "ifu_rdata_val",    64'(o_ifu_rdata[l]),  64'(32'h0000_0413));
         chk(l, "ifu_lsu_quiet",    64'(o_lsu_rvalid[l]), 64'(0));
      end
      step();
      set_mem(0, 0, 0);

      // Contention: both requesters valid continuously
      set_ifu(1, 32'h0000_0100);
      set_lsu(1, 32'h0000_0200, 0, 0, 0);
      set_mem(1, 1, 32'h55);
      gcnt = '{0, 0};
      gseq = '{0, 0};
      ifu_rdy0 = 0;
      for (int c = 0; c < 40 && (gcnt[0] < 4 || gcnt[1] < 4); c++) begin
         @(negedge clk);
         if (o_ifu_ready[0]) ifu_rdy0++;
         for (int l = 0; l < 2; l++) begin
            if (gcnt[l] < 4 && o_lsu_ready[l]) begin gseq[l] = gseq[l] * 4 + 2; gcnt[l]++; end
            else if (gcnt[l] < 4 && o_ifu_ready[l]) begin gseq[l] = gseq[l] * 4 + 1; gcnt[l]++; end
         end
         step();
      end
      chk(0, "prio_grants", 64'(gcnt[0]), 64'(4));
      chk(1, "rr_grants",   64'(gcnt[1]), 64'(4));
      chk(0, "prio_seq_lsu_only", 64'(gseq[0]), 64'(8'b10_10_10_10));
      chk(1, "rr_seq_alternate",  64'(gseq[1]), 64'(8'b10_01_10_01));
      chk(0, "prio_ifu_ready_never", 64'(ifu_rdy0), 64'(0));
      set_ifu(0, 0);
      set_lsu(0, 0, 0, 0, 0);
      repeat (3) step();
      set_mem(0, 0, 0);
      step();

      // LSU write with memory stalling for five cycles
      set_lsu(1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'b0011);
      step();
      set_lsu(0, 32'hFFFF_FFFF, 0, 32'h0, 4'b1111);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         for (int l = 0; l < 2; l++) begin
            chk(l, "wr_stall_valid", 64'(o_mem_valid[l]), 64'(1));
            chk(l, "wr_stall_addr",  64'(o_mem_addr[l]),  64'(32'h8000_1000));
            chk(l, "wr_stall_data",  64'(o_mem_wdata[l]), 64'(32'hDEAD_BEEF));
            chk(l, "wr_stall_ctl",   64'({o_mem_wen[l], o_mem_wmask[l]}), 64'(5'b1_0011));
         end
         step();
      end
      set_mem(1, 0, 0);
      step();
      set_mem(0, 1, 32'h1234_5678);
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
         chk(l, "wr_lsu_rvalid", 64'(o_lsu_rvalid[l]), 64'(1));
         chk(l, "wr_lsu_rdata",  64'(o_lsu_rdata[l]),  64'(32'h1234_5678));
         chk(l, "wr_ifu_quiet",  64'(o_ifu_rvalid[l]), 64'(0));
      end
      step();
      set_mem(0, 0, 0);

      // Watchdog: memory never accepts
      set_ifu(1, 32'h8000_0040);
      step();
      set_ifu(0, 0);
      found_at = '{0, 0};
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         for (int l = 0; l < 2; l++)
            if (found_at[l] == 0 && o_ifu_rvalid[l]) begin
               found_at[l] = k;
               f_err[l]    = {o_ifu_err[l], o_mem_valid[l]};
               f_data[l]   = o_ifu_rdata[l];
            end
         step();
      end
      for (int l = 0; l < 2; l++) begin
         chk(l, "tmo_cycle", 64'(found_at[l]), 64'(8));
         if (found_at[l] != 0) begin
            chk(l, "tmo_err_mv", 64'(f_err[l]),  64'(2'b10));
            chk(l, "tmo_rdata",  64'(f_data[l]), 64'(0));
         end
      end
      set_mem(0, 1, 32'hABCD_0000);
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
         chk(l, "stray_ifu", 64'(o_ifu_rvalid[l]), 64'(0));
         chk(l, "stray_lsu", 64'(o_lsu_rvalid[l]), 64'(0));
      end
      step();
      set_mem(0, 0, 0);

      // Response lands exactly on the last watchdog cycle
      set_ifu(1, 32'h8000_0080);
      step();
      set_ifu(0, 0);
      set_mem(1, 0, 0);
      step();
      set_mem(0, 0, 0);
      repeat (6) step();
      set_mem(0, 1, 32'hCAFE_F00D);
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
         chk(l, "tie_rvalid", 64'(o_ifu_rvalid[l]), 64'(1));
         chk(l, "tie_err",    64'(o_ifu_err[l]),    64'(0));
         chk(l, "tie_rdata",  64'(o_ifu_rdata[l]),  64'(32'hCAFE_F00D));
      end
      step();
      set_mem(0, 0, 0);

      // Reset while waiting for the response
      set_ifu(1, 32'h8000_00C0);
      step();
      set_ifu(0, 0);
      set_mem(1, 0, 0);
      step();
      set_mem(0, 0, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
         chk(l, "mrst_mem_valid", 64'(o_mem_valid[l]), 64'(0));
         chk(l, "mrst_owner",     64'(o_owner[l]),     64'(0));
      end
      set_mem(0, 1, 32'h77);
      @(negedge clk);
      for (int l = 0; l < 2; l++) chk(l, "mrst_no_resp", 64'(o_ifu_rvalid[l]), 64'(0));
      step();
      set_mem(0, 0, 0);
      set_ifu(1, 32'h8000_0100);
      @(negedge clk);
      for (int l = 0; l < 2; l++) chk(l, "mrst_new_ready", 64'(o_ifu_ready[l]), 64'(1));
      step();
      set_ifu(0, 0);
      @(negedge clk);
      for (int l = 0; l < 2; l++) chk(l, "mrst_new_addr", 64'(o_mem_addr[l]), 64'(32'h8000_0100));
      set_mem(1, 0, 0);
      step();
      set_mem(0, 1, 32'h1);
      step();
      set_mem(0, 0, 0);

      // Randomized traffic, independent per lane, with occasional resets
      for (int c = 0; c < 3000; c++) begin
         for (int l = 0; l < 2; l++) begin
            i_ifu_valid[l]  = 1'($urandom_range(0, 1));
            i_ifu_addr[l]   = $urandom;
            i_lsu_valid[l]  = 1'($urandom_range(0, 1));
            i_lsu_addr[l]   = $urandom;
            i_lsu_wen[l]    = 1'($urandom_range(0, 1));
            i_lsu_wdata[l]  = $urandom;
            i_lsu_wmask[l]  = 4'($urandom_range(0, 15));
            i_mem_ready[l]  = ($urandom_range(0, 2) == 0);
            i_mem_rvalid[l] = ($urandom_range(0, 3) == 0);
            i_mem_rdata[l]  = $urandom;
         end
         rst = ($urandom_range(0, 299) == 0);
         step();
      end
      rst = 1'b0;
      set_ifu(0, 0);
      set_lsu(0, 0, 0, 0, 0);
      set_mem(0, 0, 0);
      repeat (TO + 2) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single core memory request/response port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Grants one requester at a time and latches that request.
- Drives the memory port until the response returns, then routes the response back to the owner only.
- A watchdog counter turns a hung transaction into an error response so the pipeline cannot deadlock.

Parameters:
- TIMEOUT, 1024: cycles allowed from grant to response before an error response is forced; must be ≥2.
- RR_MODE, 0: 0 = fixed priority, LSU wins. 1 = round-robin, the last owner loses a tie.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- ifu_valid  input  1  IFU read request
- ifu_ready  output  1  IFU request accepted this cycle
- ifu_addr  input  32  IFU fetch address
- ifu_rvalid  output  1  one-cycle response pulse to IFU
- ifu_rdata  output  32  IFU response data
- ifu_err  output  1  IFU response is a timeout error
- lsu_valid  input  1  LSU request
- lsu_ready  output  1  LSU request accepted this cycle
- lsu_addr  input  32  LSU address
- lsu_wen  input  1  1 = write
- lsu_wdata  input  32  write data
- lsu_wmask  input  4  byte strobes
- lsu_rvalid  output  1  one-cycle response pulse to LSU
- lsu_rdata  output  32  LSU response data
- lsu_err  output  1  LSU response is a timeout error
- mem_valid  output  1  request to memory
- mem_ready  input  1  memory accepted request
- mem_addr  output  32  latched address
- mem_wen  output  1  latched write enable
- mem_wdata  output  32  latched write data
- mem_wmask  output  4  latched mask; 4'b0000 for IFU
- mem_rvalid  input  1  memory response valid
- mem_rdata  input  32  memory response data
- owner_out  output  2  debug: 00 none, 01 IFU, 10 LSU

Behaviour:
- States: IDLE, REQ, RESP.
- Reset (synchronous, rst high at a clk edge):
  - state = IDLE, all latched fields 0, watchdog counter 0, RR pointer favours LSU.
  - Every output is 0, including ready, rvalid, err and mem_valid.
  - Asserting rst mid-transaction abandons it; no response is delivered to either requester.
- IDLE arbitration (combinational):
  - ifu_ready/lsu_ready are high only for the selected requester, and only in IDLE.
  - With a single requester, that requester is selected.
  - When both request: RR_MODE=0 selects LSU. RR_MODE=1 selects the one that was not the previous owner.
- Accept: valid && ready at edge N. Latch addr/wen/wdata/wmask (IFU: wen=0, wmask=0) and the owner, clear the counter, go to REQ.
  - mem_valid is high from cycle N+1.
  - Requester inputs are ignored after the accept edge.
- REQ:
  - mem_valid = 1 with the latched fields stable.
  - mem_valid && mem_ready moves to RESP; mem_valid drops the next cycle.
- RESP:
  - mem_valid = 0.
  - When mem_rvalid is high: owner_rvalid = 1 (same-cycle combinational), owner_rdata = mem_rdata, owner_err = 0. Go to IDLE.
  - The other requester's rvalid stays 0.
  - Minimum accept-to-response is 2 cycles (N+1 handshake, N+2 response).
- Watchdog:
  - Counter increments every cycle in REQ or RESP.
  - If it equals TIMEOUT-1 and no completing mem_rvalid is present, then at that cycle: owner_rvalid = 1, owner_err = 1, owner_rdata = 0, mem_valid = 0. Go to IDLE.
  - A real mem_rvalid in the same cycle wins: err = 0, data passes through.
- mem_rvalid while in IDLE or REQ (late or spurious response) is ignored; nothing is forwarded.
- Back-to-back: the edge that returns to IDLE allows a new accept in the following cycle. The bus is never granted in the same cycle as a response.
- RR pointer updates on accept only.
- owner_out reflects the latched owner in REQ/RESP and is 00 in IDLE.

Test Plan:
- Single IFU read: ifu_valid, addr 0x8000_0000; mem_ready next cycle; mem_rvalid one cycle later with 0x0000_0413 -> mem_addr=0x8000_0000, mem_wmask=0, ifu_rvalid pulse with 0x0000_0413, lsu_rvalid stays 0.
- Contention, RR_MODE=0: both valid continuously -> LSU is granted every time, ifu_ready never rises. RR_MODE=1 -> grants alternate LSU, IFU, LSU, IFU.
- LSU write: addr 0x8000_1000, wdata 0xDEAD_BEEF, wmask 4'b0011; mem_ready held low 5 cycles -> mem_valid and fields stay stable 5 cycles; lsu_rvalid pulses after mem_rvalid.
- Timeout, TIMEOUT=8: IFU request, mem_ready never asserted -> ifu_rvalid=1, ifu_err=1, rdata=0 exactly 8 cycles after accept; state IDLE. A later stray mem_rvalid is ignored.
- Timeout tie: mem_rvalid arrives exactly on the TIMEOUT-1 cycle -> err=0, data forwarded.
- Reset mid-RESP: rst high one cycle -> mem_valid, all rvalid, owner_out are 0 next cycle. A subsequent mem_rvalid is ignored; a new request is accepted normally.
